// File: rtl/mest_pro_pkg.sv
// Shared types for the MEST Pro execute unit.
// MEST_PRO_EXEC_DIV_EN adds the DIV FSM state.
package mest_pro_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpMul = 4'd2,
    OpAnd = 4'd3,
    OpOr  = 4'd4,
    OpShr = 4'd5,
    OpShl = 4'd6,
    OpNot = 4'd7,
    OpJmp = 4'd8,
    OpRet = 4'd9,
    OpDiv = 4'd10,
    OpXor = 4'd11,
    OpAdc = 4'd12,
    OpSbb = 4'd13,
    OpCmp = 4'd14,
    OpEnd = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
`ifdef MEST_PRO_EXEC_DIV_EN
    StDiv  = 2'd2,
`endif
    StMul  = 2'd1
  } state_e;

endpackage

// File: rtl/mest_pro_exec_iter.sv
// Iterative shift-add multiplier, one step per clock, DATA_W steps.
// MEST_PRO_EXEC_DIV_EN adds an unsigned restoring divider sharing the accumulator.
module mest_pro_exec_iter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef MEST_PRO_EXEC_DIV_EN
  input  logic              is_div,
`endif
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic              busy_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] acc_hi_q;
  logic [DATA_W-1:0] acc_lo_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W:0]   mul_sum;
`ifdef MEST_PRO_EXEC_DIV_EN
  logic              div_q;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_trial;
`endif

  // hi/lo are the accumulator after the current step, so the final step's
  // value can be captured by the parent on the same edge it is computed.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    hi      = mul_sum[DATA_W:1];
    lo      = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
`ifdef MEST_PRO_EXEC_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    // A zero divisor always subtracts, giving all-ones quotient and remainder=A.
    if (div_q) begin
      if (div_shift >= {1'b0, opnd_q}) begin
        hi = div_trial[DATA_W-1:0];
        lo = {acc_lo_q[DATA_W-2:0], 1'b1};
      end else begin
        hi = div_shift[DATA_W-1:0];
        lo = {acc_lo_q[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CntW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
`ifdef MEST_PRO_EXEC_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (start && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= CntW'(DATA_W);
      acc_hi_q <= '0;
      acc_lo_q <= op_b;
      opnd_q   <= op_a;
`ifdef MEST_PRO_EXEC_DIV_EN
      div_q    <= is_div;
      if (is_div) begin
        acc_lo_q <= op_a;
        opnd_q   <= op_b;
      end
`endif
    end else if (busy_q) begin
      acc_hi_q <= hi;
      acc_lo_q <= lo;
      cnt_q    <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mest_pro_exec_seq.sv
// MEST Pro execute unit: single-cycle ALU plus iterative MUL (and DIV when
// MEST_PRO_EXEC_DIV_EN is defined), with busy/done handshake and held flags.
module mest_pro_exec_seq
  import mest_pro_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MUL_FAST = 0
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_execute,
  input  logic [OP_W-1:0]   i_op_code,
  input  logic [DATA_W-1:0] i_operand1,
  input  logic [DATA_W-1:0] i_operand2,
  output logic              o_busy,
  output logic              o_exec_done,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_result_hi,
  output logic              o_carry,
  output logic              o_zero_flag,
  output logic              o_neg_flag,
  output logic              o_overflow,
  output logic              o_jump,
  output logic              o_return_pc,
  output logic              o_end_of_code
);

  localparam int unsigned Msb     = DATA_W - 1;
  localparam bit          MulIter = (MUL_FAST == 0);
`ifdef MEST_PRO_EXEC_DIV_EN
  localparam bit          DivEn   = 1'b1;
`else
  localparam bit          DivEn   = 1'b0;
`endif
  localparam bit          UseIter = MulIter || DivEn;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic              carry_q, carry_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic              done_q, done_d, jump_q, jump_d, ret_q, ret_d, end_q, end_d;

  op_e                 op;
  logic [DATA_W-1:0]   a, b;
  logic                cin;
  logic [DATA_W:0]     sum, diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   alu_lo, alu_hi, flag_src;
  logic                alu_c, alu_v, alu_keep, alu_jump, alu_ret, alu_end;

  logic              iter_start, iter_busy, iter_done;
  logic [DATA_W-1:0] iter_hi, iter_lo;
`ifdef MEST_PRO_EXEC_DIV_EN
  logic              iter_div;
  logic              div_zero_q, div_zero_d;
`endif

  assign op   = op_e'(i_op_code);
  assign a    = i_operand1;
  assign b    = i_operand2;
  assign cin  = ((op == OpAdc) || (op == OpSbb)) ? carry_q : 1'b0;
  assign sum  = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    alu_lo   = '0;
    alu_hi   = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_keep = 1'b0;
    alu_jump = 1'b0;
    alu_ret  = 1'b0;
    alu_end  = 1'b0;
    case (op)
      OpAdd, OpAdc: begin
        alu_lo = sum[DATA_W-1:0];
        alu_c  = sum[DATA_W];
        alu_v  = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
      end
      OpSub, OpSbb, OpCmp: begin
        alu_lo   = diff[DATA_W-1:0];
        alu_c    = diff[DATA_W];
        alu_v    = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
        alu_keep = (op == OpCmp);
      end
      OpMul: begin
        if (!MulIter) begin
          alu_lo = prod[DATA_W-1:0];
          alu_hi = prod[2*DATA_W-1:DATA_W];
          alu_c  = |alu_hi;
        end
      end
      OpAnd: alu_lo = a & b;
      OpOr:  alu_lo = a | b;
      OpXor: alu_lo = a ^ b;
      OpNot: alu_lo = ~a;
      OpShr: begin
        alu_lo = {1'b0, a[DATA_W-1:1]};
        alu_c  = a[0];
      end
      OpShl: begin
        alu_lo = {a[DATA_W-2:0], 1'b0};
        alu_c  = a[Msb];
      end
      OpJmp: alu_jump = 1'b1;
      OpRet: alu_ret  = 1'b1;
      OpEnd: alu_end  = 1'b1;
      default: ;
    endcase
    // CMP reports flags of A-B while the result registers hold.
    flag_src = alu_keep ? diff[DATA_W-1:0] : alu_lo;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    jump_d      = 1'b0;
    ret_d       = 1'b0;
    end_d       = 1'b0;
    iter_start  = 1'b0;
`ifdef MEST_PRO_EXEC_DIV_EN
    iter_div    = 1'b0;
    div_zero_d  = div_zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_execute) begin
          if (MulIter && (op == OpMul)) begin
            iter_start = 1'b1;
            state_d    = StMul;
`ifdef MEST_PRO_EXEC_DIV_EN
          end else if (op == OpDiv) begin
            iter_start = 1'b1;
            iter_div   = 1'b1;
            div_zero_d = (b == '0);
            state_d    = StDiv;
`endif
          end else begin
            done_d = 1'b1;
            jump_d = alu_jump;
            ret_d  = alu_ret;
            end_d  = alu_end;
            if (!alu_keep) begin
              result_d    = alu_lo;
              result_hi_d = alu_hi;
            end
            carry_d = alu_c;
            zero_d  = (flag_src == '0);
            neg_d   = flag_src[Msb];
            ovf_d   = alu_v;
          end
        end
      end
      StMul: begin
        if (iter_done) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          result_d    = iter_lo;
          result_hi_d = iter_hi;
          carry_d     = |iter_hi;
          zero_d      = (iter_lo == '0);
          neg_d       = iter_lo[Msb];
          ovf_d       = 1'b0;
        end else if (!iter_busy) begin
          state_d = StIdle;
        end
      end
`ifdef MEST_PRO_EXEC_DIV_EN
      StDiv: begin
        if (iter_done) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          result_d    = iter_lo;
          result_hi_d = iter_hi;
          carry_d     = div_zero_q;
          zero_d      = (iter_lo == '0);
          neg_d       = iter_lo[Msb];
          ovf_d       = 1'b0;
        end else if (!iter_busy) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      jump_q      <= 1'b0;
      ret_q       <= 1'b0;
      end_q       <= 1'b0;
`ifdef MEST_PRO_EXEC_DIV_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      jump_q      <= jump_d;
      ret_q       <= ret_d;
      end_q       <= end_d;
`ifdef MEST_PRO_EXEC_DIV_EN
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  if (UseIter) begin : g_iter
    mest_pro_exec_iter #(
      .DATA_W(DATA_W)
    ) u_iter (
      .clk   (clk),
      .reset (i_reset),
      .start (iter_start),
`ifdef MEST_PRO_EXEC_DIV_EN
      .is_div(iter_div),
`endif
      .op_a  (i_operand1),
      .op_b  (i_operand2),
      .busy  (iter_busy),
      .done  (iter_done),
      .hi    (iter_hi),
      .lo    (iter_lo)
    );
  end else begin : g_no_iter
    assign iter_busy = 1'b0;
    assign iter_done = 1'b0;
    assign iter_hi   = '0;
    assign iter_lo   = '0;
  end

  assign o_busy        = (state_q != StIdle);
  assign o_exec_done   = done_q;
  assign o_result      = result_q;
  assign o_result_hi   = result_hi_q;
  assign o_carry       = carry_q;
  assign o_zero_flag   = zero_q;
  assign o_neg_flag    = neg_q;
  assign o_overflow    = ovf_q;
  assign o_jump        = jump_q;
  assign o_return_pc   = ret_q;
  assign o_end_of_code = end_q;

endmodule

// File: tb/tb_mest_pro_exec_seq.sv
// Directed bench for mest_pro_exec_seq (DATA_W=8, iterative multiply);
// DIV checks follow MEST_PRO_EXEC_DIV_EN.
module tb_mest_pro_exec_seq;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_execute = 1'b0;
  logic [3:0] i_op_code = 4'd0;
  logic [7:0] i_operand1 = 8'h00;
  logic [7:0] i_operand2 = 8'h00;
  logic       o_busy, o_exec_done, o_carry, o_zero_flag, o_neg_flag, o_overflow;
  logic       o_jump, o_return_pc, o_end_of_code;
  logic [7:0] o_result, o_result_hi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mest_pro_exec_seq #(
    .DATA_W  (8),
    .MUL_FAST(0)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_execute    (i_execute),
    .i_op_code    (i_op_code),
    .i_operand1   (i_operand1),
    .i_operand2   (i_operand2),
    .o_busy       (o_busy),
    .o_exec_done  (o_exec_done),
    .o_result     (o_result),
    .o_result_hi  (o_result_hi),
    .o_carry      (o_carry),
    .o_zero_flag  (o_zero_flag),
    .o_neg_flag   (o_neg_flag),
    .o_overflow   (o_overflow),
    .o_jump       (o_jump),
    .o_return_pc  (o_return_pc),
    .o_end_of_code(o_end_of_code)
  );

  // flags = {carry, zero, neg, ovf}; ctl = {jump, ret, end}
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
    logic [2:0] ctl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] res, input logic [3:0] flags,
                              input logic [2:0] ctl);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flags = flags; v.ctl = ctl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d_op%0d", idx, v.op);
    @(negedge clk);
    i_op_code = v.op; i_operand1 = v.a; i_operand2 = v.b; i_execute = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'(o_exec_done), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_result"}, 32'(o_result), 32'(v.res));
    chk({tag, "_hi"}, 32'(o_result_hi), 32'd0);
    chk({tag, "_flags"}, 32'({o_carry, o_zero_flag, o_neg_flag, o_overflow}), 32'(v.flags));
    chk({tag, "_ctl"}, 32'({o_jump, o_return_pc, o_end_of_code}), 32'(v.ctl));
  endtask

  // Iterative op; an ADD is held on i_execute for the first busy cycle and must be ignored.
  task automatic run_multi(input string name, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_lo,
                           input logic [7:0] exp_hi, input logic exp_c);
    int lat;
    int busy_gaps;
    @(negedge clk);
    i_op_code = op; i_operand1 = a; i_operand2 = b; i_execute = 1'b1;
    @(posedge clk); #1;
    chk({name, "_busy_start"}, 32'(o_busy), 32'd1);
    i_op_code = 4'd0; i_operand1 = 8'h01; i_operand2 = 8'h01;
    lat = 0;
    busy_gaps = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) i_execute = 1'b0;
      if (!o_exec_done && !o_busy) busy_gaps++;
    end while (!o_exec_done && lat < 40);
    chk({name, "_latency"}, 32'(lat), 32'd8);
    chk({name, "_busy_gaps"}, 32'(busy_gaps), 32'd0);
    chk({name, "_busy_end"}, 32'(o_busy), 32'd0);
    chk({name, "_lo"}, 32'(o_result), 32'(exp_lo));
    chk({name, "_hi"}, 32'(o_result_hi), 32'(exp_hi));
    chk({name, "_flags"}, 32'({o_carry, o_zero_flag, o_neg_flag, o_overflow}),
        32'({exp_c, exp_lo == 8'h00, exp_lo[7], 1'b0}));
    @(posedge clk); #1;
    chk({name, "_no_extra_done"}, 32'(o_exec_done), 32'd0);
    chk({name, "_hold"}, 32'(o_result), 32'(exp_lo));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_result"}, 32'(o_result), 32'd0);
    chk({name, "_hi"}, 32'(o_result_hi), 32'd0);
    chk({name, "_flags"}, 32'({o_carry, o_zero_flag, o_neg_flag, o_overflow}), 32'd0);
    chk({name, "_ctrl"}, 32'({o_busy, o_exec_done, o_jump, o_return_pc, o_end_of_code}), 32'd0);
  endtask

  initial begin
    int done_cnt;
    vec_t nop;

    // {carry, zero, neg, ovf}
    vecs.push_back(mk(4'd0,  8'hC8, 8'h64, 8'h2C, 4'b1000, 3'b000)); // ADD 200+100
    vecs.push_back(mk(4'd12, 8'h01, 8'h01, 8'h03, 4'b0000, 3'b000)); // ADC with cin=1
    vecs.push_back(mk(4'd1,  8'h05, 8'h05, 8'h00, 4'b0100, 3'b000));
    vecs.push_back(mk(4'd1,  8'h03, 8'h05, 8'hFE, 4'b1010, 3'b000));
    vecs.push_back(mk(4'd14, 8'h03, 8'h05, 8'hFE, 4'b1010, 3'b000)); // CMP holds result
    vecs.push_back(mk(4'd3,  8'hF0, 8'h3C, 8'h30, 4'b0000, 3'b000));
    vecs.push_back(mk(4'd4,  8'hF0, 8'h0F, 8'hFF, 4'b0010, 3'b000));
    vecs.push_back(mk(4'd11, 8'hAA, 8'hFF, 8'h55, 4'b0000, 3'b000));
    vecs.push_back(mk(4'd5,  8'h81, 8'h00, 8'h40, 4'b1000, 3'b000));
    vecs.push_back(mk(4'd6,  8'h81, 8'h00, 8'h02, 4'b1000, 3'b000));
    vecs.push_back(mk(4'd7,  8'h0F, 8'h00, 8'hF0, 4'b0010, 3'b000));
    vecs.push_back(mk(4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011, 3'b000)); // signed overflow
    vecs.push_back(mk(4'd1,  8'h00, 8'h01, 8'hFF, 4'b1010, 3'b000));
    vecs.push_back(mk(4'd13, 8'h10, 8'h05, 8'h0A, 4'b0000, 3'b000)); // SBB with borrow in
    vecs.push_back(mk(4'd13, 8'h80, 8'h01, 8'h7F, 4'b0001, 3'b000));
    vecs.push_back(mk(4'd12, 8'hFF, 8'h01, 8'h00, 4'b1100, 3'b000));
    vecs.push_back(mk(4'd12, 8'h00, 8'h00, 8'h01, 4'b0000, 3'b000));
    vecs.push_back(mk(4'd14, 8'h05, 8'h05, 8'h01, 4'b0100, 3'b000)); // zero from A-B
    vecs.push_back(mk(4'd8,  8'h12, 8'h34, 8'h00, 4'b0100, 3'b100));
    vecs.push_back(mk(4'd9,  8'h12, 8'h34, 8'h00, 4'b0100, 3'b010));
    vecs.push_back(mk(4'd15, 8'h12, 8'h34, 8'h00, 4'b0100, 3'b001));

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    i_reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    @(negedge clk);
    i_execute = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", 32'(o_exec_done), 32'd0);
    chk("idle_ctl", 32'({o_jump, o_return_pc, o_end_of_code}), 32'd0);
    chk("idle_zero_hold", 32'(o_zero_flag), 32'd1);

    run_multi("mul_15x17", 4'd2, 8'd15, 8'd17, 8'hFF, 8'h00, 1'b0);
    run_multi("mul_ffxff", 4'd2, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1);

    // Reset three cycles into a multiply aborts it without a done pulse.
    @(negedge clk);
    i_op_code = 4'd2; i_operand1 = 8'd15; i_operand2 = 8'd17; i_execute = 1'b1;
    @(posedge clk); #1;
    i_execute = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("mul_abort");
    @(negedge clk);
    i_reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_exec_done || o_busy) done_cnt++;
    end
    chk("mul_abort_quiet", 32'(done_cnt), 32'd0);
    run_multi("mul_after_reset", 4'd2, 8'h0C, 8'h0B, 8'h84, 8'h00, 1'b0);

`ifdef MEST_PRO_EXEC_DIV_EN
    run_multi("div_100_7", 4'd10, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run_multi("div_by_zero", 4'd10, 8'd9, 8'd0, 8'hFF, 8'd9, 1'b1);
`else
    nop = mk(4'd10, 8'h09, 8'h03, 8'h00, 4'b0100, 3'b000);
    apply_vec(nop, 99);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
